// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and the rest of the core.
// The slave modport is the sequencer's view of the bundle. The master modport is the driving side.
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        hazard_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_next;
  logic        pc_enable;
  logic        stall_if_id;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;
  logic [15:0] stall_cnt;

  modport slave (
    input  pc_cur, hazard_stall, br_taken, br_target, halt_req, resume,
    output pc_next, pc_enable, stall_if_id, flush_if_id, flush_id_ex, halted, stall_cnt
  );

  modport master (
    output pc_cur, hazard_stall, br_taken, br_target, halt_req, resume,
    input  pc_next, pc_enable, stall_if_id, flush_if_id, flush_id_ex, halted, stall_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: boot, load-use stall, branch redirect and ebreak halt/drain/resume.
// Outputs are combinational from registered state plus current inputs, so control acts in the same cycle.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } state_t;

  localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_next;
  logic        pc_enable;
  logic        stall_if_id;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;
  logic [31:0] br_aligned;

  assign br_aligned = bus.br_target & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    saved_pc_d  = saved_pc_q;
    stall_cnt_d = stall_cnt_q;
    pc_next     = bus.pc_cur;
    pc_enable   = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_next     = RESET_VECTOR;
        pc_enable   = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q == BOOT_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // A taken branch squashes the younger instructions that raised halt/stall.
        if (bus.br_taken) begin
          pc_next     = br_aligned;
          pc_enable   = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (bus.halt_req) begin
          flush_if_id = 1'b1;
          saved_pc_d  = bus.pc_cur;
          cnt_d       = 4'd0;
          state_d     = ST_DRAIN;
        end else if (bus.hazard_stall) begin
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end else begin
          pc_next   = bus.pc_cur + 32'd4;
          pc_enable = 1'b1;
        end
      end

      ST_DRAIN: begin
        flush_if_id = 1'b1;
        // An older branch still resolving in EX retargets where we resume.
        if (bus.br_taken) begin
          saved_pc_d  = br_aligned;
          flush_id_ex = 1'b1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        halted      = 1'b1;
        flush_if_id = 1'b1;
        if (bus.resume) begin
          pc_next   = saved_pc_q;
          pc_enable = 1'b1;
          halted    = 1'b0;
          state_d   = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (rst) begin
      pc_next     = RESET_VECTOR;
      pc_enable   = 1'b1;
      stall_if_id = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      cnt_q       <= 4'd0;
      saved_pc_q  <= RESET_VECTOR;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      saved_pc_q  <= saved_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_next     = pc_next;
  assign bus.pc_enable   = pc_enable;
  assign bus.stall_if_id = stall_if_id;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_id_ex = flush_id_ex;
  assign bus.halted      = halted;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with a queue scoreboard and a negedge monitor.
module tb_pc_sequencer;

  typedef struct packed {
    logic [31:0] pc_next;
    logic        pc_enable;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic [15:0] stall_cnt;
    logic        chk_pc;
  } exp_t;

  logic clk;
  logic rst;
  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .BOOT_CYCLES (4),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pcn, input logic en, input logic st,
                              input logic fi, input logic fe, input logic h,
                              input logic [15:0] sc);
    exp_t e;
    e.pc_next     = pcn;
    e.pc_enable   = en;
    e.stall_if_id = st;
    e.flush_if_id = fi;
    e.flush_id_ex = fe;
    e.halted      = h;
    e.stall_cnt   = sc;
    e.chk_pc      = en;
    return e;
  endfunction

  function automatic exp_t boot_e(input logic [15:0] sc);
    return mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, sc);
  endfunction

  // One cycle: drive inputs just after the rising edge, optionally queue the expectation.
  task automatic applyStimulus(input string nm, input logic r, input logic [31:0] pc,
                               input logic hz, input logic br, input logic [31:0] tgt,
                               input logic hr, input logic rs, input bit chk, input exp_t e);
    @(posedge clk);
    #1;
    rst              = r;
    bus.pc_cur       = pc;
    bus.hazard_stall = hz;
    bus.br_taken     = br;
    bus.br_target    = tgt;
    bus.halt_req     = hr;
    bus.resume       = rs;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic checkOutput(input string nm, input exp_t e);
    exp_t a;
    a.pc_next     = e.chk_pc ? bus.pc_next : 32'h0;
    a.pc_enable   = bus.pc_enable;
    a.stall_if_id = bus.stall_if_id;
    a.flush_if_id = bus.flush_if_id;
    a.flush_id_ex = bus.flush_id_ex;
    a.halted      = bus.halted;
    a.stall_cnt   = bus.stall_cnt;
    a.chk_pc      = e.chk_pc;
    if (!e.chk_pc) e.pc_next = 32'h0;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("[TB] FAIL %s: got pc_next=%h en=%b st=%b fi=%b fe=%b h=%b sc=%h, want pc_next=%h en=%b st=%b fi=%b fe=%b h=%b sc=%h",
               nm, a.pc_next, a.pc_enable, a.stall_if_id, a.flush_if_id, a.flush_id_ex, a.halted, a.stall_cnt,
               e.pc_next, e.pc_enable, e.stall_if_id, e.flush_if_id, e.flush_id_ex, e.halted, e.stall_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checkOutput(nm, e);
    end
  end

  initial begin
    rst              = 1'b1;
    bus.pc_cur       = 32'h0;
    bus.hazard_stall = 1'b0;
    bus.br_taken     = 1'b0;
    bus.br_target    = 32'h0;
    bus.halt_req     = 1'b0;
    bus.resume       = 1'b0;

    // Reset and boot
    applyStimulus("reset0", 1, 32'h0, 0, 0, 32'h0, 0, 0, 1, boot_e(16'd0));
    applyStimulus("reset1", 1, 32'h0, 0, 0, 32'h0, 0, 0, 1, boot_e(16'd0));
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("boot%0d", i), 0, 32'h0, 1, 1, 32'h55, 1, 1, 1, boot_e(16'd0));
    applyStimulus("run_first", 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, mk(32'h4, 1, 0, 0, 0, 0, 16'd0));

    // Load-use stall
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("stall%0d", i), 0, 32'h100, 1, 0, 32'h0, 0, 0, 1,
                    mk(32'h0, 0, 1, 0, 1, 0, 16'(i)));
    applyStimulus("after_stall", 0, 32'h100, 0, 0, 32'h0, 0, 0, 1, mk(32'h104, 1, 0, 0, 0, 0, 16'd3));

    // Redirect beats stall and halt
    applyStimulus("redirect", 0, 32'h104, 1, 1, 32'h203, 1, 0, 1, mk(32'h200, 1, 0, 1, 1, 0, 16'd3));
    applyStimulus("post_redirect", 0, 32'h200, 0, 0, 32'h0, 0, 0, 1, mk(32'h204, 1, 0, 0, 0, 0, 16'd3));

    // Halt, drain (stall ignored), halt with br ignored, resume
    applyStimulus("halt_req", 0, 32'h40, 0, 0, 32'h0, 1, 0, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'd3));
    applyStimulus("drain0", 0, 32'h44, 1, 0, 32'h0, 1, 1, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'd3));
    applyStimulus("drain1", 0, 32'h44, 1, 0, 32'h0, 0, 0, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'd3));
    applyStimulus("drain2", 0, 32'h44, 0, 0, 32'h0, 0, 0, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'd3));
    applyStimulus("halted", 0, 32'h44, 1, 1, 32'h900, 1, 0, 1, mk(32'h0, 0, 0, 1, 0, 1, 16'd3));
    applyStimulus("resume", 0, 32'h44, 0, 0, 32'h0, 1, 1, 1, mk(32'h40, 1, 0, 1, 0, 0, 16'd3));
    applyStimulus("run_after_resume", 0, 32'h40, 0, 0, 32'h0, 0, 1, 1, mk(32'h44, 1, 0, 0, 0, 0, 16'd3));

    // Redirect during drain retargets the resume PC
    applyStimulus("halt_req2", 0, 32'h40, 0, 0, 32'h0, 1, 0, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'd3));
    applyStimulus("drain2_0", 0, 32'h44, 0, 0, 32'h0, 0, 0, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'd3));
    applyStimulus("drain2_br", 0, 32'h44, 0, 1, 32'h800, 0, 0, 1, mk(32'h0, 0, 0, 1, 1, 0, 16'd3));
    applyStimulus("drain2_2", 0, 32'h44, 0, 0, 32'h0, 0, 0, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'd3));
    applyStimulus("halted2", 0, 32'h44, 0, 0, 32'h0, 0, 0, 1, mk(32'h0, 0, 0, 1, 0, 1, 16'd3));
    applyStimulus("resume2", 0, 32'h44, 0, 0, 32'h0, 0, 1, 1, mk(32'h800, 1, 0, 1, 0, 0, 16'd3));

    // PC wrap
    applyStimulus("pc_wrap", 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 0, 1, mk(32'h0, 1, 0, 0, 0, 0, 16'd3));

    // Stall counter saturation
    for (int i = 0; i < 32'h0000_FFFF + 5; i++)
      applyStimulus("long_stall", 0, 32'h10, 1, 0, 32'h0, 0, 0, 0, mk(32'h0, 0, 1, 0, 1, 0, 16'hFFFF));
    applyStimulus("sat_run", 0, 32'h10, 0, 0, 32'h0, 0, 0, 1, mk(32'h14, 1, 0, 0, 0, 0, 16'hFFFF));
    applyStimulus("sat_stall", 0, 32'h14, 1, 0, 32'h0, 0, 0, 1, mk(32'h0, 0, 1, 0, 1, 0, 16'hFFFF));
    applyStimulus("sat_hold", 0, 32'h14, 0, 0, 32'h0, 0, 0, 1, mk(32'h18, 1, 0, 0, 0, 0, 16'hFFFF));

    // Reset in the middle of a drain
    applyStimulus("halt_req3", 0, 32'h80, 0, 0, 32'h0, 1, 0, 1, mk(32'h0, 0, 0, 1, 0, 0, 16'hFFFF));
    applyStimulus("rst_in_drain", 1, 32'h84, 0, 0, 32'h0, 0, 0, 1, boot_e(16'hFFFF));
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("reboot%0d", i), 0, 32'h84, 0, 0, 32'h0, 0, 1, 1, boot_e(16'd0));
    applyStimulus("run_after_reboot", 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, mk(32'h4, 1, 0, 0, 0, 0, 16'd0));

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
